// File: rtl/spot_gen_pkg.sv
// Shared constants for the multi-spot rectangle generator: config field codes
// and the width used for position+size comparisons.
package spot_gen_pkg;

  localparam logic [1:0] FIELD_HPOS   = 2'd0;
  localparam logic [1:0] FIELD_VPOS   = 2'd1;
  localparam logic [1:0] FIELD_WIDTH  = 2'd2;
  localparam logic [1:0] FIELD_HEIGHT = 2'd3;

  // One bit wider than the widest operand so pos+size can never wrap.
  function automatic int cmp_width(input int coord_w, input int size_w);
    return ((coord_w > size_w) ? coord_w : size_w) + 1;
  endfunction

endpackage

// File: rtl/spot_window_cmp.sv
// One spot channel: shadow/active geometry registers, frame-start commit and
// the combinational window hit test against the beam counters.
module spot_window_cmp
  import spot_gen_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [1:0]         wr_field,
  input  logic [COORD_W-1:0] wr_data,
  input  logic               en,
  input  logic [COORD_W-1:0] h_count,
  input  logic [COORD_W-1:0] v_count,
  output logic               hit
);

  localparam int CW = cmp_width(COORD_W, SIZE_W);

  logic [COORD_W-1:0] sh_hpos, sh_vpos, act_hpos, act_vpos;
  logic [SIZE_W-1:0]  sh_width, sh_height, act_width, act_height;
  logic [CW-1:0]      data_ext;
  logic [CW-1:0]      hpos_e, vpos_e, width_e, height_e, h_e, v_e;

  // Size fields take the low SIZE_W bits; zero-extension covers SIZE_W > COORD_W.
  assign data_ext = CW'(wr_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_hpos   <= '0;
      sh_vpos   <= '0;
      sh_width  <= '0;
      sh_height <= '0;
    end else if (wr_en) begin
      case (wr_field)
        FIELD_HPOS:   sh_hpos   <= wr_data;
        FIELD_VPOS:   sh_vpos   <= wr_data;
        FIELD_WIDTH:  sh_width  <= data_ext[SIZE_W-1:0];
        default:      sh_height <= data_ext[SIZE_W-1:0];
      endcase
    end
  end

  // Writes are stalled during frame_start, so the commit always sees whole fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_hpos   <= '0;
      act_vpos   <= '0;
      act_width  <= '0;
      act_height <= '0;
    end else if (frame_start) begin
      act_hpos   <= sh_hpos;
      act_vpos   <= sh_vpos;
      act_width  <= sh_width;
      act_height <= sh_height;
    end
  end

  always_comb begin
    hpos_e   = CW'(act_hpos);
    vpos_e   = CW'(act_vpos);
    width_e  = CW'(act_width);
    height_e = CW'(act_height);
    h_e      = CW'(h_count);
    v_e      = CW'(v_count);
    hit      = en
            && (hpos_e < h_e) && (h_e < hpos_e + width_e)
            && (vpos_e < v_e) && (v_e < vpos_e + height_e);
  end

endmodule

// File: rtl/spot_generator_multi.sv
// Multi-spot rectangle generator: config decode into per-spot shadow registers,
// registered per-spot/combined video, and per-frame collision flags.
module spot_generator_multi
  import spot_gen_pkg::*;
#(
  parameter int NUM_SPOTS = 4,
  parameter int COORD_W   = 10,
  parameter int SIZE_W    = 10,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COORD_W-1:0]   h_count,
  input  logic [COORD_W-1:0]   v_count,
  input  logic                 frame_start,
  input  logic [NUM_SPOTS-1:0] spot_en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [1:0]           cfg_field,
  input  logic [COORD_W-1:0]   cfg_data,
  output logic [NUM_SPOTS-1:0] spot_out,
  output logic                 video_out,
  output logic [NUM_SPOTS-1:0] collision,
  output logic                 collision_valid
);

  logic                 ready_q;
  logic                 cfg_fire;
  logic [NUM_SPOTS-1:0] hit;
  logic [NUM_SPOTS-1:0] spot_p1;
  logic                 video_p1;
  logic [NUM_SPOTS-1:0] overlap;
  logic [NUM_SPOTS-1:0] flag_p2;
  logic [NUM_SPOTS-1:0] collision_p2;
  logic                 vld_p2;

  function automatic logic multi_hit(input logic [NUM_SPOTS-1:0] v);
    int cnt;
    cnt = 0;
    for (int k = 0; k < NUM_SPOTS; k++) cnt += int'(v[k]);
    return cnt >= 2;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= 1'b1;
  end

  assign cfg_ready = ready_q & ~frame_start;
  assign cfg_fire  = cfg_valid & cfg_ready;

  // Out-of-range cfg_idx matches no channel, so the write is simply dropped.
  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
    logic wr_en;
    assign wr_en = cfg_fire && (int'(cfg_idx) == i);

    spot_window_cmp #(
      .COORD_W (COORD_W),
      .SIZE_W  (SIZE_W)
    ) u_win (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .wr_field    (cfg_field),
      .wr_data     (cfg_data),
      .en          (spot_en[i]),
      .h_count     (h_count),
      .v_count     (v_count),
      .hit         (hit[i])
    );
  end

  // Stage 1: registered video
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spot_p1  <= '0;
      video_p1 <= 1'b0;
    end else begin
      spot_p1  <= hit;
      video_p1 <= |hit;
    end
  end

  always_comb begin
    overlap = '0;
    if (multi_hit(spot_p1)) overlap = spot_p1;
  end

  // Stage 2: collision accumulation; the frame_start cycle's overlap closes the old frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_p2      <= '0;
      collision_p2 <= '0;
      vld_p2       <= 1'b0;
    end else if (frame_start) begin
      collision_p2 <= flag_p2 | overlap;
      flag_p2      <= '0;
      vld_p2       <= 1'b1;
    end else begin
      flag_p2      <= flag_p2 | overlap;
      vld_p2       <= 1'b0;
    end
  end

  assign spot_out        = spot_p1;
  assign video_out       = video_p1;
  assign collision       = collision_p2;
  assign collision_valid = vld_p2;

endmodule

// File: tb/tb_spot_generator_multi.sv
// Scoreboard bench for spot_generator_multi (3 spots, 10-bit coordinates).
module tb_spot_generator_multi;
  import spot_gen_pkg::*;

  localparam int NS = 3;

  logic          clk;
  logic          reset_n;
  logic [9:0]    h_count, v_count;
  logic          frame_start;
  logic [NS-1:0] spot_en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_idx;
  logic [1:0]    cfg_field;
  logic [9:0]    cfg_data;
  logic [NS-1:0] spot_out;
  logic          video_out;
  logic [NS-1:0] collision;
  logic          collision_valid;

  spot_generator_multi #(
    .NUM_SPOTS (NS),
    .COORD_W   (10),
    .SIZE_W    (10),
    .IDX_W     (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .h_count         (h_count),
    .v_count         (v_count),
    .frame_start     (frame_start),
    .spot_en         (spot_en),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_idx         (cfg_idx),
    .cfg_field       (cfg_field),
    .cfg_data        (cfg_data),
    .spot_out        (spot_out),
    .video_out       (video_out),
    .collision       (collision),
    .collision_valid (collision_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: geometry as plain ints (no wrap), index 0..3 = hpos,vpos,width,height
  int            m_sh  [NS][4];
  int            m_act [NS][4];
  logic [NS-1:0] m_spot, m_flag, m_coll;
  logic          m_cv;
  logic [NS:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int f = 0; f < 4; f++) begin
        m_sh[s][f]  = 0;
        m_act[s][f] = 0;
      end
    m_spot = '0;
    m_flag = '0;
    m_coll = '0;
    m_cv   = 1'b0;
  endtask

  function automatic bit model_hit(input int s, input int h, input int v);
    return (m_act[s][0] < h) && (h < m_act[s][0] + m_act[s][2]) &&
           (m_act[s][1] < v) && (v < m_act[s][1] + m_act[s][3]);
  endfunction

  function automatic int popc(input logic [NS-1:0] x);
    int c;
    c = 0;
    for (int k = 0; k < NS; k++) c += int'(x[k]);
    return c;
  endfunction

  task automatic cycle(input int h, input int v, input logic [NS-1:0] en, input logic fs,
                       input logic cv, input logic [1:0] ci, input logic [1:0] cf,
                       input int cd);
    logic [NS-1:0] eh, ov;
    logic [NS:0]   e;
    h_count     = 10'(h);
    v_count     = 10'(v);
    spot_en     = en;
    frame_start = fs;
    cfg_valid   = cv;
    cfg_idx     = ci;
    cfg_field   = cf;
    cfg_data    = 10'(cd);
    #1;
    check("cfg_ready", 32'(cfg_ready), 32'(!fs));
    eh = '0;
    for (int s = 0; s < NS; s++) if (en[s] && model_hit(s, h, v)) eh[s] = 1'b1;
    exp_q.push_back({eh, |eh});
    ov = (popc(m_spot) >= 2) ? m_spot : '0;
    if (fs) begin
      m_coll = m_flag | ov;
      m_flag = '0;
      m_cv   = 1'b1;
      for (int s = 0; s < NS; s++)
        for (int f = 0; f < 4; f++) m_act[s][f] = m_sh[s][f];
    end else begin
      m_flag = m_flag | ov;
      m_cv   = 1'b0;
    end
    if (cv && !fs && int'(ci) < NS) m_sh[int'(ci)][int'(cf)] = cd;
    m_spot = eh;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("spot_out", 32'(spot_out), 32'(e[NS:1]));
    check("video_out", 32'(video_out), 32'(e[0]));
    check("collision_valid", 32'(collision_valid), 32'(m_cv));
    check("collision", 32'(collision), 32'(m_coll));
  endtask

  task automatic idle(input int h, input int v, input logic [NS-1:0] en, input logic fs);
    cycle(h, v, en, fs, 1'b0, 2'd0, 2'd0, 0);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [1:0] f, input int d);
    cycle(0, 0, '0, 1'b0, 1'b1, idx, f, d);
  endtask

  task automatic wr_spot(input logic [1:0] idx, input int hp, input int vp, input int w, input int ht);
    wr(idx, FIELD_HPOS, hp);
    wr(idx, FIELD_VPOS, vp);
    wr(idx, FIELD_WIDTH, w);
    wr(idx, FIELD_HEIGHT, ht);
  endtask

  task automatic sweep(input int v, input int h0, input int h1, input logic [NS-1:0] en);
    for (int h = h0; h <= h1; h++) idle(h, v, en, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    h_count = '0; v_count = '0; frame_start = 1'b0; spot_en = '1;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_spot_out", 32'(spot_out), 32'd0);
    check("rst_video_out", 32'(video_out), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_collision_valid", 32'(collision_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    spot_en = '0;
    @(posedge clk);
    #1;
    check("cfg_ready_after_reset", 32'(cfg_ready), 32'd1);

    // Single spot, first frame_start after reset
    wr_spot(2'd0, 100, 50, 20, 10);
    idle(0, 0, 3'b001, 1'b1);
    sweep(55, 98, 122, 3'b001);
    sweep(50, 99, 121, 3'b001);
    sweep(60, 99, 121, 3'b001);
    sweep(51, 100, 102, 3'b001);
    sweep(59, 118, 120, 3'b001);

    // Shadow commit and stalled write on frame_start
    wr(2'd0, FIELD_HPOS, 200);
    sweep(55, 99, 102, 3'b001);
    sweep(55, 199, 202, 3'b001);
    cycle(0, 0, 3'b001, 1'b1, 1'b1, 2'd0, FIELD_HPOS, 300);
    cycle(0, 0, 3'b001, 1'b0, 1'b1, 2'd0, FIELD_HPOS, 300);
    sweep(55, 199, 202, 3'b001);
    sweep(55, 299, 302, 3'b001);
    idle(0, 0, 3'b001, 1'b1);
    sweep(55, 199, 202, 3'b001);
    sweep(55, 299, 302, 3'b001);

    // Clipping past the counter range, then zero width
    wr_spot(2'd1, 1000, 0, 100, 20);
    idle(0, 0, 3'b010, 1'b1);
    sweep(5, 998, 1023, 3'b010);
    sweep(5, 0, 3, 3'b010);
    sweep(5, 74, 78, 3'b010);
    wr(2'd1, FIELD_WIDTH, 0);
    idle(0, 0, 3'b010, 1'b1);
    sweep(5, 999, 1003, 3'b010);
    sweep(5, 1020, 1023, 3'b010);

    // Out-of-range index is accepted and dropped
    wr(2'd3, FIELD_HPOS, 555);
    wr(2'd3, FIELD_WIDTH, 300);
    idle(0, 0, 3'b011, 1'b1);
    sweep(55, 299, 302, 3'b011);
    sweep(5, 999, 1002, 3'b011);

    // Collision: spots 0 and 1 overlap, spot 2 disjoint
    wr_spot(2'd0, 100, 50, 20, 10);
    wr_spot(2'd1, 110, 55, 20, 10);
    wr_spot(2'd2, 400, 300, 10, 10);
    idle(0, 0, 3'b111, 1'b1);
    for (int v = 52; v <= 62; v += 2) sweep(v, 98, 132, 3'b111);
    sweep(305, 399, 411, 3'b111);
    idle(0, 0, 3'b111, 1'b1);
    for (int v = 52; v <= 62; v += 2) sweep(v, 98, 132, 3'b101);
    sweep(305, 399, 411, 3'b101);
    idle(0, 0, 3'b101, 1'b1);
    sweep(57, 105, 106, 3'b111);
    sweep(57, 125, 126, 3'b111);
    idle(0, 0, 3'b111, 1'b1);

    // Overlap seen exactly on the frame_start cycle closes the old frame
    idle(115, 57, 3'b111, 1'b0);
    idle(0, 0, 3'b111, 1'b1);
    sweep(57, 105, 106, 3'b111);
    idle(0, 0, 3'b111, 1'b1);
    idle(115, 57, 3'b111, 1'b0);
    idle(0, 0, 3'b111, 1'b1);

    // Asynchronous reset mid-frame with outputs active
    idle(115, 57, 3'b111, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_spot_out", 32'(spot_out), 32'd0);
    check("async_rst_video_out", 32'(video_out), 32'd0);
    check("async_rst_collision", 32'(collision), 32'd0);
    check("async_rst_collision_valid", 32'(collision_valid), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_spot_out", 32'(spot_out), 32'd0);
    check("held_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("cfg_ready_after_rerelease", 32'(cfg_ready), 32'd1);
    idle(115, 57, 3'b111, 1'b0);
    idle(0, 0, 3'b111, 1'b1);
    idle(0, 0, 3'b111, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
